// File: rtl/game_timer.sv
// Elapsed mm:ss stopwatch for the snake game: BCD count from start of play, freeze on game_over,
// registered 7-segment codes per digit and a one-cycle tick per counted second.
module game_timer #(
  parameter int TICK_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       game_over,
  output logic [6:0] led_min_h,
  output logic [6:0] led_min_l,
  output logic [6:0] led_sec_h,
  output logic [6:0] led_sec_l,
  output logic       sec_tick,
  output logic       running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PSC_ZERO = {PW{1'b0}};
  localparam logic [6:0]    SEG_INV  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [6:0]    SEG_ZERO = 7'b0111111 ^ SEG_INV;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  logic [1:0]    state_r, state_nx_s;
  logic [PW-1:0] psc_r, psc_nx_s;
  logic [3:0]    sec_l_r, sec_h_r, min_l_r, min_h_r;
  logic [3:0]    sec_l_nx_s, sec_h_nx_s, min_l_nx_s, min_h_nx_s;
  logic          tick_nx_s;
  logic          sat_s;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b0111111;
      4'd1:    c = 7'b0000110;
      4'd2:    c = 7'b1011011;
      4'd3:    c = 7'b1001111;
      4'd4:    c = 7'b1100110;
      4'd5:    c = 7'b1101101;
      4'd6:    c = 7'b1111101;
      4'd7:    c = 7'b0000111;
      4'd8:    c = 7'b1111111;
      4'd9:    c = 7'b1101111;
      default: c = 7'b0000000;
    endcase
    return c ^ SEG_INV;
  endfunction

  assign sat_s = (min_h_r == 4'd9) && (min_l_r == 4'd9) && (sec_h_r == 4'd5) && (sec_l_r == 4'd9);

  // Next-state, prescaler and BCD counter logic
  always_comb begin
    state_nx_s = state_r;
    psc_nx_s   = psc_r;
    sec_l_nx_s = sec_l_r;
    sec_h_nx_s = sec_h_r;
    min_l_nx_s = min_l_r;
    min_h_nx_s = min_h_r;
    tick_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !game_over) state_nx_s = ST_RUN;
        else                     state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        // A freeze on the wrap edge wins: the second is dropped and no tick is issued.
        if (game_over) begin
          state_nx_s = ST_STOPPED;
        end else if (psc_r == PSC_MAX) begin
          psc_nx_s  = PSC_ZERO;
          tick_nx_s = 1'b1;
          if (sat_s) begin
            sec_l_nx_s = sec_l_r;
          end else if (sec_l_r != 4'd9) begin
            sec_l_nx_s = sec_l_r + 4'd1;
          end else begin
            sec_l_nx_s = 4'd0;
            if (sec_h_r != 4'd5) begin
              sec_h_nx_s = sec_h_r + 4'd1;
            end else begin
              sec_h_nx_s = 4'd0;
              if (min_l_r != 4'd9) begin
                min_l_nx_s = min_l_r + 4'd1;
              end else begin
                min_l_nx_s = 4'd0;
                min_h_nx_s = min_h_r + 4'd1;
              end
            end
          end
        end else begin
          psc_nx_s = psc_r + PW'(1);
        end
      end
      ST_STOPPED: begin
        if (start && !game_over) begin
          state_nx_s = ST_RUN;
          psc_nx_s   = PSC_ZERO;
          sec_l_nx_s = 4'd0;
          sec_h_nx_s = 4'd0;
          min_l_nx_s = 4'd0;
          min_h_nx_s = 4'd0;
        end else begin
          state_nx_s = ST_STOPPED;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        psc_nx_s   = PSC_ZERO;
        sec_l_nx_s = 4'd0;
        sec_h_nx_s = 4'd0;
        min_l_nx_s = 4'd0;
        min_h_nx_s = 4'd0;
      end
    endcase
  end

  // State, counters and registered outputs; segments trail the BCD digits by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      psc_r     <= PSC_ZERO;
      sec_l_r   <= 4'd0;
      sec_h_r   <= 4'd0;
      min_l_r   <= 4'd0;
      min_h_r   <= 4'd0;
      sec_tick  <= 1'b0;
      running   <= 1'b0;
      led_sec_l <= SEG_ZERO;
      led_sec_h <= SEG_ZERO;
      led_min_l <= SEG_ZERO;
      led_min_h <= SEG_ZERO;
    end else begin
      state_r   <= state_nx_s;
      psc_r     <= psc_nx_s;
      sec_l_r   <= sec_l_nx_s;
      sec_h_r   <= sec_h_nx_s;
      min_l_r   <= min_l_nx_s;
      min_h_r   <= min_h_nx_s;
      sec_tick  <= tick_nx_s;
      running   <= (state_nx_s == ST_RUN);
      led_sec_l <= seg_encode(sec_l_r);
      led_sec_h <= seg_encode(sec_h_r);
      led_min_l <= seg_encode(min_l_r);
      led_min_h <= seg_encode(min_h_r);
    end
  end

endmodule
